// File: rtl/test_splitter.sv
// test_splitter: registered 32-bit word splitter.
// Captures input word a every rising clock edge and presents the halfword
// swap, the individual halfword and byte fields, and the low halfword
// sign- and zero-extended. Every output comes from the same sampled word.
// Reset is asynchronous and active-high and clears every output register.
module test_splitter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] o,
  output logic [15:0]      hi,
  output logic [15:0]      lo,
  output logic [7:0]       b3,
  output logic [7:0]       b2,
  output logic [7:0]       b1,
  output logic [7:0]       b0,
  output logic [31:0]      sext_lo,
  output logic [31:0]      zext_lo
);

  // Next-state values for each output register, all taken from the same a
  logic [WIDTH-1:0] o_d;
  logic [15:0]      hi_d;
  logic [15:0]      lo_d;
  logic [7:0]       b3_d;
  logic [7:0]       b2_d;
  logic [7:0]       b1_d;
  logic [7:0]       b0_d;
  logic [31:0]      sext_lo_d;
  logic [31:0]      zext_lo_d;

  // Output registers
  logic [WIDTH-1:0] o_q;
  logic [15:0]      hi_q;
  logic [15:0]      lo_q;
  logic [7:0]       b3_q;
  logic [7:0]       b2_q;
  logic [7:0]       b1_q;
  logic [7:0]       b0_q;
  logic [31:0]      sext_lo_q;
  logic [31:0]      zext_lo_q;

  // Field extraction: pure bit-selects and concatenations of the input word
  always_comb begin
    o_d       = {a[15:0], a[31:16]};
    hi_d      = a[31:16];
    lo_d      = a[15:0];
    b3_d      = a[31:24];
    b2_d      = a[23:16];
    b1_d      = a[15:8];
    b0_d      = a[7:0];
    sext_lo_d = {{16{a[15]}}, a[15:0]};
    zext_lo_d = {16'h0000, a[15:0]};
  end

  // Capture all fields together each edge; async reset clears them at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_q       <= {WIDTH{1'b0}};
      hi_q      <= 16'h0000;
      lo_q      <= 16'h0000;
      b3_q      <= 8'h00;
      b2_q      <= 8'h00;
      b1_q      <= 8'h00;
      b0_q      <= 8'h00;
      sext_lo_q <= 32'h0000_0000;
      zext_lo_q <= 32'h0000_0000;
    end else begin
      o_q       <= o_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      b3_q      <= b3_d;
      b2_q      <= b2_d;
      b1_q      <= b1_d;
      b0_q      <= b0_d;
      sext_lo_q <= sext_lo_d;
      zext_lo_q <= zext_lo_d;
    end
  end

  assign o       = o_q;
  assign hi      = hi_q;
  assign lo      = lo_q;
  assign b3      = b3_q;
  assign b2      = b2_q;
  assign b1      = b1_q;
  assign b0      = b0_q;
  assign sext_lo = sext_lo_q;
  assign zext_lo = zext_lo_q;

endmodule

// File: tb/tb_test_splitter.sv
// tb_test_splitter: directed and randomized checks of test_splitter against
// an arithmetic reference model of the field split.
module tb_test_splitter;

  logic        clk;
  logic        reset;
  logic [31:0] a;
  logic [31:0] o;
  logic [15:0] hi;
  logic [15:0] lo;
  logic [7:0]  b3;
  logic [7:0]  b2;
  logic [7:0]  b1;
  logic [7:0]  b0;
  logic [31:0] sext_lo;
  logic [31:0] zext_lo;

  int checks = 0;
  int errors = 0;

  test_splitter #(.WIDTH(32)) dut (
    .clk     (clk),
    .reset   (reset),
    .a       (a),
    .o       (o),
    .hi      (hi),
    .lo      (lo),
    .b3      (b3),
    .b2      (b2),
    .b1      (b1),
    .b0      (b0),
    .sext_lo (sext_lo),
    .zext_lo (zext_lo)
  );

  // 10-time-unit clock, first rising edge at t=5
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Reference: derive every field of word w with plain arithmetic
  task automatic check_all(input string tag, input logic [31:0] w);
    logic [31:0] hi_e, lo_e, o_e, s_e;
    hi_e = w / 32'd65536;
    lo_e = w % 32'd65536;
    o_e  = lo_e * 32'd65536 + hi_e;
    s_e  = (lo_e >= 32'd32768) ? (lo_e + 32'hFFFF_0000) : lo_e;
    cmp({tag, ".o"},       o,                o_e);
    cmp({tag, ".hi"},      {16'h0000, hi},   hi_e);
    cmp({tag, ".lo"},      {16'h0000, lo},   lo_e);
    cmp({tag, ".b3"},      {24'h0, b3},      w / 32'd16777216);
    cmp({tag, ".b2"},      {24'h0, b2},      (w / 32'd65536) % 32'd256);
    cmp({tag, ".b1"},      {24'h0, b1},      (w / 32'd256) % 32'd256);
    cmp({tag, ".b0"},      {24'h0, b0},      w % 32'd256);
    cmp({tag, ".sext_lo"}, sext_lo,          s_e);
    cmp({tag, ".zext_lo"}, zext_lo,          lo_e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] prev;
    logic [31:0] w;

    // 1. Reset held, no edges yet
    reset = 1'b1;
    a     = 32'h0000_0003;
    #2;
    check_all("reset_noedge", 32'h0);
    step();
    check_all("reset_held", 32'h0);

    // 2. Basic capture
    reset = 1'b0;
    a     = 32'h0000_0003;
    step();
    check_all("basic", 32'h0000_0003);

    // 3. Sign extension
    a = 32'hFFFF_8000;
    step();
    check_all("sext", 32'hFFFF_8000);
    cmp("sext.upper_lit", sext_lo, 32'hFFFF_8000);

    // 4. Byte lanes
    a = 32'h1234_5678;
    step();
    check_all("bytes", 32'h1234_5678);
    cmp("bytes.o_lit", o, 32'h5678_1234);

    // Sign boundary on either side of 0x8000
    a = 32'hABCD_7FFF;
    step();
    check_all("bound_7fff", 32'hABCD_7FFF);
    a = 32'h0000_8000;
    step();
    check_all("bound_8000", 32'h0000_8000);

    // 5. Latency: change a between edges, outputs hold until next edge
    prev = 32'h0000_8000;
    a    = 32'hDEAD_BEEF;
    #3;
    check_all("latency_hold", prev);
    step();
    check_all("latency_update", 32'hDEAD_BEEF);

    // 6. Async reset mid-run
    reset = 1'b1;
    #1;
    check_all("async_reset", 32'h0);
    a = 32'hCAFE_F00D;
    #1;
    reset = 1'b0;
    #1;
    check_all("after_release_noedge", 32'h0);
    step();
    check_all("after_release", 32'hCAFE_F00D);

    // Randomized words, with the sign bit forced both ways periodically
    for (int i = 0; i < 200; i++) begin
      w = $urandom();
      if (i % 4 == 1) w[15] = 1'b1;
      else if (i % 4 == 3) w[15] = 1'b0;
      else w = w;
      a = w;
      step();
      check_all("random", w);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
